// File: rtl/read_data_return_buffer.sv
// Assembles backend read beats into full lines tagged with their command ID and
// returns them to the frontend through a first-word fall-through line FIFO.
module read_data_return_buffer #(
    parameter int DATA_WIDTH = 1024,
    parameter int BEAT_WIDTH = 128,
    parameter int FIFO_DEPTH = 4,
    parameter int ID_WIDTH   = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_beat_valid,
    input  logic [BEAT_WIDTH-1:0] i_beat_data,
    input  logic [ID_WIDTH-1:0]   i_beat_id,
    output logic                  o_beat_ready,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic [ID_WIDTH-1:0]   o_id,
    output logic                  o_full,
    output logic                  o_empty,
    output logic [FIFO_DEPTH:0]   o_count,
    output logic                  o_id_err
);
    localparam int BEATS   = DATA_WIDTH / BEAT_WIDTH;
    localparam int CNT_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int ENTRIES = 1 << FIFO_DEPTH;
    localparam logic [CNT_W-1:0]    LAST_BEAT = CNT_W'(BEATS - 1);
    localparam logic [CNT_W-1:0]    CNT_ONE   = CNT_W'(1);
    localparam logic [FIFO_DEPTH:0] PTR_ONE   = (FIFO_DEPTH + 1)'(1);

    typedef enum logic [0:0] {
        IDLE,
        COLLECT
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      beat_cnt_q, beat_cnt_d;
    logic [DATA_WIDTH-1:0] line_q, line_d;
    logic [ID_WIDTH-1:0]   id_q, id_d;
    logic                  id_err_q, id_err_d;
    logic [FIFO_DEPTH:0]   wr_ptr_q, wr_ptr_d;
    logic [FIFO_DEPTH:0]   rd_ptr_q, rd_ptr_d;
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;
    logic [FIFO_DEPTH:0]   count_q, count_d;

    logic [DATA_WIDTH-1:0] mem_q    [ENTRIES];
    logic [ID_WIDTH-1:0]   mem_id_q [ENTRIES];
    logic [DATA_WIDTH-1:0] shadow_q [ENTRIES];

    logic                  beat_acc;
    logic                  push;
    logic                  pop;
    logic [ID_WIDTH-1:0]   push_id;
    logic [FIFO_DEPTH-1:0] wr_idx;
    logic [FIFO_DEPTH-1:0] rd_idx;

    assign wr_idx = wr_ptr_q[FIFO_DEPTH-1:0];
    assign rd_idx = rd_ptr_q[FIFO_DEPTH-1:0];

    // Only the completing beat needs a free slot; earlier beats land in line_q.
    assign o_beat_ready = !((beat_cnt_q == LAST_BEAT) && full_q);
    assign beat_acc     = i_beat_valid && o_beat_ready;
    assign pop          = o_valid && i_ready;

    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        line_d     = line_q;
        id_d       = id_q;
        id_err_d   = id_err_q;
        push       = 1'b0;
        push_id    = id_q;
        if (beat_acc) begin
            for (int unsigned k = 0; k < BEATS; k++) begin
                if (beat_cnt_q == CNT_W'(k)) begin
                    line_d[k*BEAT_WIDTH +: BEAT_WIDTH] = i_beat_data;
                end
            end
            case (state_q)
                IDLE: begin
                    id_d    = i_beat_id;
                    push_id = i_beat_id;
                end
                COLLECT: begin
                    if (i_beat_id != id_q) begin
                        id_err_d = 1'b1;
                    end
                end
                default: ;
            endcase
            if (beat_cnt_q == LAST_BEAT) begin
                push       = 1'b1;
                beat_cnt_d = '0;
                state_d    = IDLE;
            end else begin
                beat_cnt_d = beat_cnt_q + CNT_ONE;
                state_d    = COLLECT;
            end
        end
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        empty_d  = (wr_ptr_d == rd_ptr_d);
        full_d   = (wr_ptr_d[FIFO_DEPTH] != rd_ptr_d[FIFO_DEPTH]) &&
                   (wr_ptr_d[FIFO_DEPTH-1:0] == rd_ptr_d[FIFO_DEPTH-1:0]);
        count_d  = wr_ptr_d - rd_ptr_d;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= IDLE;
            beat_cnt_q <= '0;
            id_q       <= '0;
            id_err_q   <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            id_q       <= id_d;
            id_err_q   <= id_err_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            count_q    <= count_d;
        end
    end

    always_ff @(posedge i_clk) begin
        line_q <= line_d;
        if (push && !i_rst) begin
            mem_q[wr_idx]    <= line_d;
            mem_id_q[wr_idx] <= push_id;
            shadow_q[wr_idx] <= line_d;
        end
    end

    assign o_valid  = !empty_q;
    assign o_data   = mem_q[rd_idx];
    assign o_id     = mem_id_q[rd_idx];
    assign o_full   = full_q;
    assign o_empty  = empty_q;
    assign o_count  = count_q;
    assign o_id_err = id_err_q;

    a_no_push_full: assert property (@(posedge i_clk) disable iff (i_rst) !(push && full_q));
    a_no_pop_empty: assert property (@(posedge i_clk) disable iff (i_rst) !(pop && empty_q));
    a_wr_step:      assert property (@(posedge i_clk) disable iff (i_rst)
                                     push |=> (wr_ptr_q == $past(wr_ptr_q) + PTR_ONE));
    a_wr_hold:      assert property (@(posedge i_clk) disable iff (i_rst) !push |=> $stable(wr_ptr_q));
    a_rd_step:      assert property (@(posedge i_clk) disable iff (i_rst)
                                     pop |=> (rd_ptr_q == $past(rd_ptr_q) + PTR_ONE));
    a_rd_hold:      assert property (@(posedge i_clk) disable iff (i_rst) !pop |=> $stable(rd_ptr_q));
    a_pop_data:     assert property (@(posedge i_clk) disable iff (i_rst) pop |-> (o_data == shadow_q[rd_idx]));
endmodule

// File: tb/tb_read_data_return_buffer.sv
// Directed bench for read_data_return_buffer: a burst table plus hand-written
// sequences for full stall, wrap, push/pop overlap and mid-burst reset.
module tb_read_data_return_buffer;
    localparam int DW = 1024;
    localparam int BW = 128;
    localparam int FD = 4;
    localparam int IW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          beat_valid;
    logic [BW-1:0] beat_data;
    logic [IW-1:0] beat_id;
    logic          beat_ready;
    logic          valid;
    logic          ready;
    logic [DW-1:0] data;
    logic [IW-1:0] id;
    logic          full;
    logic          empty;
    logic [FD:0]   count;
    logic          id_err;

    always #5 clk = ~clk;

    read_data_return_buffer #(
        .DATA_WIDTH(DW),
        .BEAT_WIDTH(BW),
        .FIFO_DEPTH(FD),
        .ID_WIDTH  (IW)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_beat_valid(beat_valid),
        .i_beat_data (beat_data),
        .i_beat_id   (beat_id),
        .o_beat_ready(beat_ready),
        .o_valid     (valid),
        .i_ready     (ready),
        .o_data      (data),
        .o_id        (id),
        .o_full      (full),
        .o_empty     (empty),
        .o_count     (count),
        .o_id_err    (id_err)
    );

    typedef struct {
        int unsigned   tag;
        logic [IW-1:0] id;
    } exp_t;

    typedef struct {
        logic [IW-1:0] id0;
        int unsigned   bad_beat;
        logic [IW-1:0] bad_id;
        logic          exp_err;
    } burst_vec_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   done;

    function automatic logic [BW-1:0] mk_beat(input int unsigned tag, input int unsigned k);
        logic [3:0]  n;
        logic [15:0] t;
        logic [15:0] kk;
        n  = 4'(k);
        t  = 16'(tag);
        kk = 16'(k);
        if (tag == 0) return {32{n}};
        return {4{t, kk}};
    endfunction

    function automatic logic [DW-1:0] mk_line(input int unsigned tag);
        logic [DW-1:0] l;
        for (int unsigned k = 0; k < 8; k++) l[k*BW +: BW] = mk_beat(tag, k);
        return l;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_line(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            for (int unsigned k = 0; k < 8; k++) begin
                if (act[k*BW +: BW] !== exp[k*BW +: BW]) begin
                    $display("FAIL %s: beat %0d got %h, expected %h", name, k, act[k*BW +: BW], exp[k*BW +: BW]);
                    break;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [BW-1:0] d, input logic [IW-1:0] bid);
        int unsigned waited;
        waited     = 0;
        beat_valid = 1'b1;
        beat_data  = d;
        beat_id    = bid;
        @(negedge clk);
        while (!beat_ready && waited < 200) begin
            waited++;
            @(negedge clk);
        end
        if (!beat_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL beat_accept_timeout: o_beat_ready=0 for %0d cycles, expected 1", waited);
        end
        @(posedge clk);
        #1;
        beat_valid = 1'b0;
    endtask

    task automatic send_beats(input int unsigned tag, input logic [IW-1:0] id0, input int unsigned bad_beat,
                              input logic [IW-1:0] bad_id, input int unsigned k_lo, input int unsigned k_hi);
        for (int unsigned k = k_lo; k <= k_hi; k++) begin
            if (k == 7) exp_q.push_back(exp_t'{tag, id0});
            send_beat(mk_beat(tag, k), (bad_beat != 0 && k == bad_beat) ? bad_id : id0);
        end
    endtask

    task automatic drain(input string name);
        tick();
        ready = 1'b1;
        for (int unsigned w = 0; w < 200; w++) begin
            @(negedge clk);
            if (empty) break;
        end
        chk({name, "_empty"}, 128'(empty), 128'(1));
        chk({name, "_all_out"}, 128'(exp_q.size()), 128'(0));
        chk({name, "_count"}, 128'(count), 128'(0));
    endtask

    // Head of the FIFO must always be the oldest expected line, held or popped.
    always @(negedge clk) begin
        if (!rst && valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL head_unexpected: o_valid=1, expected 0 (no line outstanding)");
            end else begin
                chk_line("head_data", data, mk_line(exp_q[0].tag));
                chk("head_id", 128'(id), 128'(exp_q[0].id));
                if (ready) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        #500000;
        $fatal(1, "FAIL watchdog: time limit reached before end of test");
    end

    initial begin
        burst_vec_t vecs[5];
        vecs[0] = '{4'hA, 0, 4'h0, 1'b0};
        vecs[1] = '{4'hF, 0, 4'h0, 1'b0};
        vecs[2] = '{4'h2, 3, 4'h5, 1'b1};
        vecs[3] = '{4'h7, 0, 4'h0, 1'b1};
        vecs[4] = '{4'h0, 0, 4'h0, 1'b1};

        rst        = 1'b1;
        beat_valid = 1'b0;
        beat_data  = '0;
        beat_id    = '0;
        ready      = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_empty", 128'(empty), 128'(1));
        chk("rst_full", 128'(full), 128'(0));
        chk("rst_count", 128'(count), 128'(0));
        chk("rst_valid", 128'(valid), 128'(0));
        chk("rst_beat_ready", 128'(beat_ready), 128'(1));
        chk("rst_id_err", 128'(id_err), 128'(0));

        // single burst, ready held high
        tick();
        send_beats(0, 4'h3, 0, 4'h0, 0, 6);
        @(negedge clk);
        chk("t1_valid_before_last", 128'(valid), 128'(0));
        tick();
        send_beats(0, 4'h3, 0, 4'h0, 7, 7);
        @(negedge clk);
        chk("t1_valid", 128'(valid), 128'(1));
        chk("t1_id", 128'(id), 128'(3));
        chk_line("t1_data", data, mk_line(0));
        chk("t1_count", 128'(count), 128'(1));
        tick();
        @(negedge clk);
        chk("t1_empty_after_pop", 128'(empty), 128'(1));
        chk("t1_count_after_pop", 128'(count), 128'(0));

        // burst table, including the ID-change error case
        foreach (vecs[i]) begin
            tick();
            if (vecs[i].bad_beat != 0) begin
                send_beats(10 + i, vecs[i].id0, vecs[i].bad_beat, vecs[i].bad_id, 0, vecs[i].bad_beat);
                @(negedge clk);
                chk("t5_err_set", 128'(id_err), 128'(1));
                tick();
                send_beats(10 + i, vecs[i].id0, vecs[i].bad_beat, vecs[i].bad_id, vecs[i].bad_beat + 1, 7);
            end else begin
                send_beats(10 + i, vecs[i].id0, 0, 4'h0, 0, 7);
            end
            @(negedge clk);
            chk("vec_valid", 128'(valid), 128'(1));
            chk("vec_id", 128'(id), 128'(vecs[i].id0));
            chk_line("vec_data", data, mk_line(10 + i));
            chk("vec_id_err", 128'(id_err), 128'(vecs[i].exp_err));
            tick();
            @(negedge clk);
            chk("vec_empty", 128'(empty), 128'(1));
        end

        // fill to full, then stall the last beat of the 17th line
        tick();
        ready = 1'b0;
        for (int unsigned i = 0; i < 16; i++) send_beats(100 + i, 4'(i), 0, 4'h0, 0, 7);
        @(negedge clk);
        chk("t2_full", 128'(full), 128'(1));
        chk("t2_count16", 128'(count), 128'(16));
        tick();
        send_beats(116, 4'hC, 0, 4'h0, 0, 6);
        @(negedge clk);
        chk("t2_count_after_7beats", 128'(count), 128'(16));
        chk("t2_stall_ready", 128'(beat_ready), 128'(0));
        tick();
        exp_q.push_back(exp_t'{116, 4'hC});
        beat_valid = 1'b1;
        beat_data  = mk_beat(116, 7);
        beat_id    = 4'hC;
        tick();
        @(negedge clk);
        chk("t2_still_stalled", 128'(beat_ready), 128'(0));
        chk("t2_still_count16", 128'(count), 128'(16));
        tick();
        ready = 1'b1;
        @(negedge clk);
        chk("t2_no_same_cycle_unblock", 128'(beat_ready), 128'(0));
        tick();
        ready = 1'b0;
        @(negedge clk);
        chk("t2_full_fell", 128'(full), 128'(0));
        chk("t2_count15", 128'(count), 128'(15));
        chk("t2_ready_back", 128'(beat_ready), 128'(1));
        tick();
        beat_valid = 1'b0;
        @(negedge clk);
        chk("t2_full_again", 128'(full), 128'(1));
        chk("t2_count16_again", 128'(count), 128'(16));
        drain("t2");

        // streaming across pointer wrap under random backpressure
        tick();
        done = 1'b0;
        fork
            begin
                for (int unsigned i = 0; i < 40; i++) send_beats(200 + i, 4'(i % 16), 0, 4'h0, 0, 7);
                done = 1'b1;
            end
            begin
                while (!done) begin
                    ready = 1'($urandom_range(0, 1));
                    tick();
                end
            end
        join
        drain("t3");

        // push and pop in the same cycle with one line stored
        tick();
        ready = 1'b0;
        send_beats(300, 4'h1, 0, 4'h0, 0, 7);
        send_beats(301, 4'h8, 0, 4'h0, 0, 6);
        @(negedge clk);
        chk("t4_count1", 128'(count), 128'(1));
        tick();
        ready = 1'b1;
        send_beats(301, 4'h8, 0, 4'h0, 7, 7);
        ready = 1'b0;
        @(negedge clk);
        chk("t4_count_unchanged", 128'(count), 128'(1));
        chk("t4_new_head_id", 128'(id), 128'(8));
        chk_line("t4_new_head_data", data, mk_line(301));
        drain("t4");

        // reset in the middle of a burst
        tick();
        ready = 1'b0;
        send_beats(400, 4'h6, 0, 4'h0, 0, 3);
        rst = 1'b1;
        exp_q.delete();
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("t6_empty", 128'(empty), 128'(1));
        chk("t6_count", 128'(count), 128'(0));
        chk("t6_id_err", 128'(id_err), 128'(0));
        chk("t6_valid", 128'(valid), 128'(0));
        chk("t6_full", 128'(full), 128'(0));
        chk("t6_beat_ready", 128'(beat_ready), 128'(1));
        tick();
        send_beats(401, 4'h9, 0, 4'h0, 0, 7);
        @(negedge clk);
        chk("t6_one_line", 128'(count), 128'(1));
        chk("t6_id", 128'(id), 128'(9));
        chk_line("t6_data", data, mk_line(401));
        chk("t6_no_err", 128'(id_err), 128'(0));
        drain("t6");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
